// File: rtl/mem_seq_ctrl.sv
// Frame sequencer in front of data_mem: fills DEPTH samples, then drains them in address order.
// Optional input/output checksum comparison is enabled by defining MEM_SEQ_CHECKSUM_EN.
module mem_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  chk_err,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wEn,
    output logic                  mem_rEn,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_OUT      = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(RD_LAT);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic                   mem_wen_q, mem_wen_d;
    logic                   mem_ren_q, mem_ren_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   fill_hs_s;
    logic                   out_hs_s;

    assign fill_hs_s = (state_q == S_FILL) && in_valid && in_ready_q;
    assign out_hs_s  = (state_q == S_OUT) && out_valid_q && out_ready;

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lat_cnt_d   = lat_cnt_q;
        mem_data_d  = mem_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_FILL;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_FILL: begin
                if (fill_hs_s) begin
                    mem_wen_d  = 1'b1;
                    mem_addr_d = wr_ptr_q;
                    mem_data_d = in_data;
                    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
                    // Terminal compare on DEPTH-1 so a full-range pointer never wraps mid-frame.
                    state_d    = (wr_ptr_q == PTR_LAST) ? S_RD_ISSUE : S_FILL;
                end else begin
                    state_d    = S_FILL;
                end
            end
            S_RD_ISSUE: begin
                mem_ren_d  = 1'b1;
                mem_addr_d = rd_ptr_q;
                lat_cnt_d  = '0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // Count covers the rEn cycle plus RD_LAT cycles until mem_out is valid.
                if (lat_cnt_q == LAT_LAST) begin
                    out_data_d  = mem_out;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    lat_cnt_d   = lat_cnt_q + LAT_W'(1);
                end
            end
            S_OUT: begin
                if (out_hs_s) begin
                    out_valid_d = 1'b0;
                    if (rd_ptr_q == PTR_LAST) begin
                        state_d  = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                        state_d  = S_RD_ISSUE;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d == S_FILL);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lat_cnt_q   <= '0;
            mem_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lat_cnt_q   <= lat_cnt_d;
            mem_data_q  <= mem_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef MEM_SEQ_CHECKSUM_EN
    logic [15:0] sum_in_q, sum_in_d;
    logic [15:0] sum_out_q, sum_out_d;
    logic        chk_err_q, chk_err_d;

    // Running modulo-2^16 sums; the verdict includes the final sample so it is valid in DONE.
    always_comb begin
        sum_in_d  = sum_in_q;
        sum_out_d = sum_out_q;
        chk_err_d = chk_err_q;
        if ((state_q == S_IDLE) && start) begin
            sum_in_d  = 16'd0;
            sum_out_d = 16'd0;
            chk_err_d = 1'b0;
        end else if (fill_hs_s) begin
            sum_in_d  = sum_in_q + 16'(in_data);
        end else if (out_hs_s) begin
            sum_out_d = sum_out_q + 16'(out_data_q);
            if (rd_ptr_q == PTR_LAST) begin
                chk_err_d = (sum_in_q != sum_out_d);
            end else begin
                chk_err_d = chk_err_q;
            end
        end else begin
            chk_err_d = chk_err_q;
        end
    end

    // Checksum registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_in_q  <= 16'd0;
            sum_out_q <= 16'd0;
            chk_err_q <= 1'b0;
        end else begin
            sum_in_q  <= sum_in_d;
            sum_out_q <= sum_out_d;
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_data  = mem_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wEn   = mem_wen_q;
    assign mem_rEn   = mem_ren_q;

endmodule
